// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: three-stage floating-point adder/subtractor (align, add, normalise/round).
// One global advance signal moves every stage together under valid/ready flow control.
module fp_add_sub_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int RND_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 exception,
  output logic                 zero
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 1;   // significand including hidden bit
  localparam int AW  = FW + 2;      // aligned small operand: significand, guard, round
  localparam int SW  = FW + 4;      // sum: carry, significand, guard, round, sticky
  localparam int NW  = SW - 1;
  localparam int EW  = EXP_W + 2;   // signed headroom for exp+1 and exp-lzc
  localparam int LZW = $clog2(NW + 1);
  localparam logic [EXP_W-1:0] SH_LIMIT = EXP_W'(AW);
  localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);

  logic adv;

  // stage registers
  logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_exc_q, s1_sticky_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [FW-1:0]    s1_sig_l_q;
  logic [AW-1:0]    s1_sig_s_q;
  logic             s2_valid_q, s2_sign_q, s2_exc_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0]    s2_sum_q;
  logic             out_valid_q, exc_q, zero_q;
  logic [W-1:0]     result_q;

  // next-state values
  logic             s1_sign_d, s1_sub_d, s1_exc_d, s1_sticky_d;
  logic [EXP_W-1:0] s1_exp_d;
  logic [FW-1:0]    s1_sig_l_d;
  logic [AW-1:0]    s1_sig_s_d;
  logic [SW-1:0]    s2_sum_d;
  logic [W-1:0]     result_d;
  logic             exc_d, zero_d;

  assign adv       = out_ready | ~out_valid_q;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign exception = exc_q;
  assign zero      = zero_q;

  // ---------------- stage 1: unpack, order by magnitude, align ----------------
  logic [EXP_W-1:0] exp_a, exp_b, exp_l, exp_s, exp_diff;
  logic [FW-1:0]    sig_a, sig_b, sig_l, sig_s;
  logic             sgn_a, sgn_b, swap;
  logic [2*AW-1:0]  shift_win;

  always_comb begin
    exp_a     = a[W-2:MAN_W];
    exp_b     = b[W-2:MAN_W];
    sig_a     = (exp_a == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    sig_b     = (exp_b == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    sgn_a     = a[W-1];
    sgn_b     = b[W-1] ^ sub;
    swap      = {exp_a, sig_a} < {exp_b, sig_b};
    exp_l     = swap ? exp_b : exp_a;
    exp_s     = swap ? exp_a : exp_b;
    sig_l     = swap ? sig_b : sig_a;
    sig_s     = swap ? sig_a : sig_b;
    exp_diff  = exp_l - exp_s;
    // lower half of the window collects every bit shifted past the round position
    shift_win = {sig_s, 2'b00, {AW{1'b0}}} >> exp_diff;

    s1_sign_d  = swap ? sgn_b : sgn_a;
    s1_sub_d   = sgn_a ^ sgn_b;
    s1_exc_d   = (&exp_a) | (&exp_b);
    s1_exp_d   = exp_l;
    s1_sig_l_d = sig_l;
    if (exp_diff >= SH_LIMIT) begin
      s1_sig_s_d  = '0;
      s1_sticky_d = |sig_s;
    end else begin
      s1_sig_s_d  = shift_win[2*AW-1:AW];
      s1_sticky_d = |shift_win[AW-1:0];
    end
  end

  // ---------------- stage 2: magnitude add / subtract ----------------
  logic [SW-1:0] op_l, op_s;

  always_comb begin
    op_l     = {1'b0, s1_sig_l_q, 3'b000};
    op_s     = {1'b0, s1_sig_s_q, s1_sticky_q};
    s2_sum_d = s1_sub_q ? (op_l - op_s) : (op_l + op_s);
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZW-1:0]   lzc;
  logic             lz_found;
  logic [NW-1:0]    norm;
  logic [EW-1:0]    exp_n, exp_f;
  logic [FW:0]      sig_r;
  logic [MAN_W-1:0] man_f;
  logic             rnd_inc, uflow, ovf, sum_zero;

  always_comb begin
    lzc      = LZW'(NW);
    lz_found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!lz_found && s2_sum_q[i]) begin
        lzc      = LZW'(NW - 1 - i);
        lz_found = 1'b1;
      end
    end

    if (s2_sum_q[SW-1]) begin
      norm  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = EW'(s2_exp_q) + EW'(1);
    end else begin
      norm  = s2_sum_q[NW-1:0] << lzc;
      exp_n = EW'(s2_exp_q) - EW'(lzc);
    end

    // norm = {significand, guard, round, sticky}
    rnd_inc = (RND_EN != 0) && norm[2] && (norm[1] || norm[0] || norm[3]);
    sig_r   = {1'b0, norm[NW-1:3]} + {{FW{1'b0}}, rnd_inc};
    if (sig_r[FW]) begin
      man_f = sig_r[MAN_W:1];
      exp_f = exp_n + EW'(1);
    end else begin
      man_f = sig_r[MAN_W-1:0];
      exp_f = exp_n;
    end

    sum_zero = (s2_sum_q == '0);
    uflow    = exp_n[EW-1] || (exp_n == '0);
    ovf      = !exp_f[EW-1] && (exp_f >= EXP_MAX);

    result_d = {s2_sign_q, exp_f[EXP_W-1:0], man_f};
    exc_d    = 1'b0;
    zero_d   = 1'b0;
    if (s2_exc_q || ovf) begin
      result_d = '1;
      exc_d    = 1'b1;
    end else if (sum_zero) begin
      result_d = '0;
      zero_d   = 1'b1;
    end else if (uflow) begin
      result_d = {s2_sign_q, {(W-1){1'b0}}};
      zero_d   = 1'b1;
    end
  end

  // ---------------- control and output registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      result_q    <= s2_valid_q ? result_d : '0;
      exc_q       <= s2_valid_q & exc_d;
      zero_q      <= s2_valid_q & zero_d;
    end
  end

  // datapath registers need no reset: their contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q   <= s1_sign_d;
      s1_sub_q    <= s1_sub_d;
      s1_exc_q    <= s1_exc_d;
      s1_exp_q    <= s1_exp_d;
      s1_sig_l_q  <= s1_sig_l_d;
      s1_sig_s_q  <= s1_sig_s_d;
      s1_sticky_q <= s1_sticky_d;
      s2_sign_q   <= s1_sign_q;
      s2_exc_q    <= s1_exc_q;
      s2_exp_q    <= s1_exp_q;
      s2_sum_q    <= s2_sum_d;
    end
  end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Testbench for fp_add_sub_pipe (single precision, RNE): exact wide-integer reference model
// plus directed, random, back-pressure and reset-in-flight scenarios.
`timescale 1ns/1ps
module tb_fp_add_sub_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;

  typedef logic [299:0] big_t;
  typedef struct packed {
    logic [31:0] r;
    logic        e;
    logic        z;
  } res_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        e;
    logic        z;
  } dcase_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         exception;
  logic         zero;

  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  fp_add_sub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .RND_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exception(exception), .zero(zero)
  );

  // Exact reference: each operand becomes an integer scaled by 2^(exp-1), summed exactly,
  // then normalised and rounded to nearest-even from the exact remainder.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    res_t o;
    big_t nx, ny, n, rem, half, mant;
    int   ex, ey, p, e, sh;
    logic sx, sy, sg;
    o  = '0;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    sy = y[31] ^ s;
    if (ex == 255 || ey == 255) begin
      o.r = '1;
      o.e = 1'b1;
      return o;
    end
    nx = (ex == 0) ? '0 : (big_t'({1'b1, x[22:0]}) << (ex - 1));
    ny = (ey == 0) ? '0 : (big_t'({1'b1, y[22:0]}) << (ey - 1));
    sg = (nx >= ny) ? sx : sy;
    if (sx == sy)      n = nx + ny;
    else if (nx >= ny) n = nx - ny;
    else               n = ny - nx;
    if (n == '0) begin
      o.z = 1'b1;
      return o;
    end
    p = 0;
    for (int i = 0; i < 300; i++) if (n[i]) p = i;
    e = p - 22;
    if (e <= 0) begin
      o.r = {sg, 31'd0};
      o.z = 1'b1;
      return o;
    end
    sh   = p - 23;
    mant = n >> sh;
    if (sh > 0) begin
      rem  = n & ((big_t'(1) << sh) - big_t'(1));
      half = big_t'(1) << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + big_t'(1);
    end
    if (mant[24]) begin
      mant = mant >> 1;
      e++;
    end
    if (e >= 255) begin
      o.r = '1;
      o.e = 1'b1;
    end else begin
      o.r = {sg, 8'(e), mant[22:0]};
    end
    return o;
  endfunction

  task automatic gen_op(output logic [31:0] x, output logic [31:0] y, output logic s);
    int ex, ey, mode;
    mode = int'($urandom_range(0, 9));
    ex   = int'($urandom_range(1, 254));
    ey   = ex + int'($urandom_range(0, 60)) - 30;
    if (ey < 0)   ey = 0;
    if (ey > 254) ey = 254;
    x = {1'($urandom), 8'(ex), 23'($urandom)};
    y = {1'($urandom), 8'(ey), 23'($urandom)};
    s = 1'($urandom);
    case (mode)
      0: x[30:23] = 8'hFF;
      1: y[30:23] = 8'h00;
      2: begin y = {x[31], x[30:0] ^ 31'($urandom_range(0, 255))}; s = 1'b1; end
      3: begin x[30:23] = 8'hFE; y = {x[31], 8'hFE, 23'($urandom)}; s = 1'b0; end
      4: begin x[30:23] = 8'($urandom_range(1, 3)); y = {x[31], x[30:0] ^ 31'($urandom_range(0, 15))}; s = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    assert_cnt++;
    if ({out_valid, exception, zero} !== 3'b000) begin
      fail_cnt++; $display("FAIL reset_flags: got v/e/z=%b expected 000", {out_valid, exception, zero});
    end
    assert_cnt++;
    if (result !== 32'h0) begin
      fail_cnt++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    assert_cnt++;
    if (in_ready !== 1'b1) begin
      fail_cnt++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    $display("reset: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
  endtask

  task automatic test_latency;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      assert_cnt++;
      if (out_valid !== (c == 3)) begin
        fail_cnt++; $display("FAIL latency_valid_c%0d: got %b expected %b", c, out_valid, (c == 3));
      end
    end
    assert_cnt++;
    if ({result, exception, zero} !== {32'h40400000, 2'b00}) begin
      fail_cnt++; $display("FAIL latency_result: got %h e=%b z=%b expected 40400000 e=0 z=0", result, exception, zero);
    end
    $display("latency: 1.0+2.0 -> %h after 3 cycles", result);
  endtask

  dcase_t dir_tab [13] = '{
    '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0},
    '{32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 1'b0, 1'b0},
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b1},
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0},
    '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 1'b0, 1'b0},
    '{32'h7F800000, 32'h3F800000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
    '{32'h3F800000, 32'hFF800001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
    '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1},
    '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0},
    '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1},
    '{32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 1'b0, 1'b1},
    '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b0, 1'b1}
  };

  task automatic test_directed;
    int c;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      a = dir_tab[k].a; b = dir_tab[k].b; sub = dir_tab[k].s; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      c = 0;
      while (out_valid !== 1'b1 && c < 8) begin
        @(negedge clk);
        c++;
      end
      assert_cnt++;
      if (out_valid !== 1'b1) begin
        fail_cnt++; $display("FAIL directed_%0d_timeout: got out_valid=%b expected 1", k, out_valid);
      end else if ({result, exception, zero} !== {dir_tab[k].r, dir_tab[k].e, dir_tab[k].z}) begin
        fail_cnt++;
        $display("FAIL directed_%0d: got %h e=%b z=%b expected %h e=%b z=%b", k, result, exception, zero,
                 dir_tab[k].r, dir_tab[k].e, dir_tab[k].z);
      end
      $display("directed %0d: %h %s %h -> %h e=%b z=%b", k, dir_tab[k].a, dir_tab[k].s ? "-" : "+",
               dir_tab[k].b, result, exception, zero);
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int   sent, got, cyc;
    res_t ex;
    logic [31:0] x, y;
    logic s;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    gen_op(x, y, s);
    while (got < 300 && cyc < 3000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 300) && ($urandom_range(0, 4) != 0);
      a = x; b = y; sub = s;
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        assert_cnt++;
        if (exp_q.size() == 0) begin
          fail_cnt++; $display("FAIL random_extra: got %h expected no output", result);
        end else begin
          ex = exp_q.pop_front();
          if ({result, exception, zero} !== {ex.r, ex.e, ex.z}) begin
            fail_cnt++;
            $display("FAIL random_%0d: got %h e=%b z=%b expected %h e=%b z=%b", got, result, exception, zero,
                     ex.r, ex.e, ex.z);
          end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(x, y, s));
        sent++;
        gen_op(x, y, s);
      end
      cyc++;
    end
    in_valid = 1'b0;
    assert_cnt++;
    if (got != 300) begin
      fail_cnt++; $display("FAIL random_count: got %0d results expected 300", got);
    end
    $display("random: %0d ops sent, %0d results checked in %0d cycles", sent, got, cyc);
  endtask

  task automatic test_back_to_back;
    bit   rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] oa [8];
    logic [31:0] ob [8];
    logic        os [8];
    int   sent, got, cyc;
    logic held_chk;
    logic [31:0] held_r;
    res_t ex;
    for (int i = 0; i < 8; i++) gen_op(oa[i], ob[i], os[i]);
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; held_chk = 1'b0; held_r = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = rdy_pat[cyc % 4];
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = oa[sent]; b = ob[sent]; sub = os[sent];
      end
      #1;
      assert_cnt++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        fail_cnt++; $display("FAIL b2b_in_ready_c%0d: got %b expected %b", cyc, in_ready, out_ready | ~out_valid);
      end
      if (held_chk) begin
        assert_cnt++;
        if ({out_valid, result} !== {1'b1, held_r}) begin
          fail_cnt++; $display("FAIL b2b_hold_c%0d: got v=%b %h expected v=1 %h", cyc, out_valid, result, held_r);
        end
      end
      held_chk = (out_valid === 1'b1) && !out_ready;
      held_r   = result;
      if (out_valid === 1'b1 && out_ready) begin
        assert_cnt++;
        ex = exp_q.pop_front();
        if ({result, exception, zero} !== {ex.r, ex.e, ex.z}) begin
          fail_cnt++;
          $display("FAIL b2b_%0d: got %h e=%b z=%b expected %h e=%b z=%b", got, result, exception, zero,
                   ex.r, ex.e, ex.z);
        end
        $display("b2b result %0d: %h", got, result);
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(oa[sent], ob[sent], os[sent]));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    assert_cnt++;
    if (got != 8) begin
      fail_cnt++; $display("FAIL b2b_count: got %0d results expected 8", got);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      assert_cnt++;
      if (out_valid !== 1'b0) begin
        fail_cnt++; $display("FAIL b2b_dup_c%0d: got out_valid=%b expected 0", c, out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0;
    @(negedge clk);
    a = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      assert_cnt++;
      if (out_valid !== 1'b0) begin
        fail_cnt++; $display("FAIL midflight_rst_c%0d: got out_valid=%b expected 0", c, out_valid);
      end
      @(negedge clk);
    end
    $display("reset mid-flight: no output for discarded ops");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
